// File: rtl/t05_least_pair_scanner.sv
// Least-pair scanner for the Huffman tree builder: walks the count table over a
// one-outstanding read handshake, keeps the two smallest non-zero counts, wipes
// both entries through a write handshake and reports their indices and sum.
module t05_least_pair_scanner #(
  parameter int NUM_ENTRIES = 512,
  parameter int CNT_W       = 64,
  parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [IDX_W:0]   limit,
  output logic             rd_req,
  output logic [IDX_W-1:0] rd_addr,
  input  logic             rd_valid,
  input  logic [CNT_W-1:0] rd_data,
  output logic             wr_req,
  output logic [IDX_W-1:0] wr_addr,
  output logic [CNT_W-1:0] wr_data,
  input  logic             wr_ack,
  output logic             busy,
  output logic             done,
  output logic [1:0]       found,
  output logic [IDX_W-1:0] least1,
  output logic [IDX_W-1:0] least2,
  output logic [CNT_W:0]   sum
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, CMP, WIPE1, WIPE2, FIN} state_t;

  state_t           state;
  logic [IDX_W:0]   lim;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] rd_v;

  // Candidate slots: slot 1 holds the smallest count seen, slot 2 the runner-up
  logic             s1_vld, s2_vld;
  logic [IDX_W-1:0] s1_idx, s2_idx;
  logic [CNT_W-1:0] s1_cnt, s2_cnt;

  logic             n1_vld, n2_vld;
  logic [IDX_W-1:0] n1_idx, n2_idx;
  logic [CNT_W-1:0] n1_cnt, n2_cnt;

  logic [1:0]       pub_found;
  logic [IDX_W-1:0] pub_l1, pub_l2;
  logic [CNT_W:0]   pub_sum;
  logic [IDX_W:0]   lim_cl;
  logic             last;

  // Requested scan length never exceeds the table depth
  function automatic logic [IDX_W:0] clamp_limit(input logic [IDX_W:0] l);
    if (l > (IDX_W+1)'(NUM_ENTRIES)) return (IDX_W+1)'(NUM_ENTRIES);
    return l;
  endfunction

  // Full-width sum; an empty slot contributes nothing, and the carry is kept
  function automatic logic [CNT_W:0] pair_sum(input logic v1, input logic [CNT_W-1:0] c1,
                                              input logic v2, input logic [CNT_W-1:0] c2);
    logic [CNT_W:0] a, b;
    a = v1 ? {1'b0, c1} : '0;
    b = v2 ? {1'b0, c2} : '0;
    return a + b;
  endfunction

  assign lim_cl  = clamp_limit(limit);
  assign last    = ({1'b0, ptr} == lim - 1'b1);
  assign wr_data = '0;

  // Slot update for the count being compared; strict less-than keeps the lower index on ties
  always_comb begin
    n1_vld = s1_vld;
    n1_idx = s1_idx;
    n1_cnt = s1_cnt;
    n2_vld = s2_vld;
    n2_idx = s2_idx;
    n2_cnt = s2_cnt;
    if (state == CMP && rd_v != '0) begin
      if (!s1_vld || rd_v < s1_cnt) begin
        n2_vld = s1_vld;
        n2_idx = s1_idx;
        n2_cnt = s1_cnt;
        n1_vld = 1'b1;
        n1_idx = ptr;
        n1_cnt = rd_v;
      end else if (!s2_vld || rd_v < s2_cnt) begin
        n2_vld = 1'b1;
        n2_idx = ptr;
        n2_cnt = rd_v;
      end
    end
  end

  // Result view of the slots as published at completion; empty slots read as zero
  always_comb begin
    pub_found = {1'b0, n1_vld} + {1'b0, n2_vld};
    pub_l1    = n1_vld ? n1_idx : '0;
    pub_l2    = n2_vld ? n2_idx : '0;
    pub_sum   = pair_sum(n1_vld, n1_cnt, n2_vld, n2_cnt);
  end

  // Data storage for the returned word and slot contents; validity lives in the control block
  always_ff @(posedge clk) begin
    if (state == WAIT && rd_valid) rd_v <= rd_data;
    if (state == CMP) begin
      s1_idx <= n1_idx;
      s1_cnt <= n1_cnt;
      s2_idx <= n2_idx;
      s2_cnt <= n2_cnt;
    end
  end

  // Scan controller with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lim     <= '0;
      ptr     <= '0;
      s1_vld  <= 1'b0;
      s2_vld  <= 1'b0;
      rd_req  <= 1'b0;
      rd_addr <= '0;
      wr_req  <= 1'b0;
      wr_addr <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      found   <= '0;
      least1  <= '0;
      least2  <= '0;
      sum     <= '0;
    end else begin
      rd_req <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            lim    <= lim_cl;
            ptr    <= '0;
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
            if (lim_cl == '0) begin
              state  <= FIN;
              done   <= 1'b1;
              found  <= '0;
              least1 <= '0;
              least2 <= '0;
              sum    <= '0;
            end else begin
              state   <= REQ;
              busy    <= 1'b1;
              rd_req  <= 1'b1;
              rd_addr <= '0;
            end
          end
        end
        REQ: state <= WAIT;
        WAIT: if (rd_valid) state <= CMP;
        CMP: begin
          s1_vld <= n1_vld;
          s2_vld <= n2_vld;
          if (last) begin
            if (n1_vld && n2_vld) begin
              state   <= WIPE1;
              wr_req  <= 1'b1;
              wr_addr <= n1_idx;
            end else begin
              state  <= FIN;
              busy   <= 1'b0;
              done   <= 1'b1;
              found  <= pub_found;
              least1 <= pub_l1;
              least2 <= pub_l2;
              sum    <= pub_sum;
            end
          end else begin
            ptr     <= ptr + 1'b1;
            rd_addr <= ptr + 1'b1;
            rd_req  <= 1'b1;
            state   <= REQ;
          end
        end
        WIPE1: begin
          if (wr_ack) begin
            wr_req <= 1'b0;
            state  <= WIPE2;
          end
        end
        WIPE2: begin
          // First cycle here is the mandatory idle gap between the two writes
          if (!wr_req) begin
            wr_req  <= 1'b1;
            wr_addr <= s2_idx;
          end else if (wr_ack) begin
            wr_req <= 1'b0;
            state  <= FIN;
            busy   <= 1'b0;
            done   <= 1'b1;
            found  <= pub_found;
            least1 <= pub_l1;
            least2 <= pub_l2;
            sum    <= pub_sum;
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_t05_least_pair_scanner.sv
// Directed bench for the least-pair scanner with an SRAM read/write responder
// serviced on every falling edge and a scoreboard of expected scan results.
module tb_t05_least_pair_scanner;
  localparam int N  = 8;
  localparam int CW = 64;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [IW:0]   limit;
  logic          rd_req;
  logic [IW-1:0] rd_addr;
  logic          rd_valid;
  logic [CW-1:0] rd_data;
  logic          wr_req;
  logic [IW-1:0] wr_addr;
  logic [CW-1:0] wr_data;
  logic          wr_ack;
  logic          busy;
  logic          done;
  logic [1:0]    found;
  logic [IW-1:0] least1;
  logic [IW-1:0] least2;
  logic [CW:0]   sum;

  always #5 clk = ~clk;

  t05_least_pair_scanner #(.NUM_ENTRIES(N), .CNT_W(CW), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .limit(limit),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .busy(busy), .done(done), .found(found), .least1(least1), .least2(least2), .sum(sum)
  );

  typedef struct {
    logic [1:0]  found;
    int          l1;
    int          l2;
    logic [CW:0] sum;
  } res_t;

  logic [CW-1:0] mem [N];
  int checks   = 0;
  int failures = 0;

  bit            rd_pend, rd_prev;
  int            rd_dn, rd_n;
  logic [IW-1:0] rd_pa;
  int            rd_hits [N];
  int            lat_min, lat_max, ack_dly;
  bit            wr_pend;
  logic [IW-1:0] wr_pa;
  int            wr_wait, wr_n;
  int            wr_log [$];
  res_t          exp_q [$];
  int            exp_wr [$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory responder: one read in flight with chosen latency, writes acked after ack_dly
  task automatic service();
    if (!rst_n) begin
      rd_valid = 1'b0;
      rd_pend  = 1'b0;
      rd_prev  = 1'b0;
      wr_ack   = 1'b0;
      wr_pend  = 1'b0;
    end else begin
      rd_valid = 1'b0;
      if (rd_pend) begin
        rd_dn--;
        if (rd_dn == 0) begin
          rd_valid = 1'b1;
          rd_data  = mem[rd_pa];
          rd_pend  = 1'b0;
        end
      end
      if (rd_req) begin
        chk("rd_pulse", 128'(rd_prev), 128'(0));
        chk("rd_single", 128'(rd_pend), 128'(0));
        chk("rd_addr", 128'(rd_addr), 128'(rd_n));
        rd_n++;
        rd_hits[rd_addr]++;
        rd_pend = 1'b1;
        rd_pa   = rd_addr;
        rd_dn   = int'($urandom_range(lat_max, lat_min));
      end
      rd_prev = rd_req;
      if (wr_ack) begin
        wr_ack = 1'b0;
      end else if (wr_req) begin
        if (!wr_pend) begin
          wr_pend = 1'b1;
          wr_pa   = wr_addr;
          wr_wait = 0;
          wr_n++;
        end else begin
          chk("wr_addr_hold", 128'(wr_addr), 128'(wr_pa));
        end
        if (wr_wait == ack_dly) begin
          wr_ack = 1'b1;
          chk("wr_data", 128'(wr_data), 128'(0));
          mem[wr_pa] = wr_data;
          wr_log.push_back(int'(wr_pa));
          wr_pend = 1'b0;
        end else begin
          wr_wait++;
        end
      end else if (wr_pend) begin
        chk("wr_req_hold", 128'(wr_req), 128'(1));
        wr_pend = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    service();
  endtask

  task automatic clear_logs();
    rd_n = 0;
    wr_n = 0;
    for (int i = 0; i < N; i++) rd_hits[i] = 0;
    wr_log.delete();
  endtask

  task automatic expect_res(input int f, input int l1, input int l2, input logic [CW:0] s);
    res_t r;
    r.found = 2'(f);
    r.l1    = l1;
    r.l2    = l2;
    r.sum   = s;
    exp_q.push_back(r);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rd_req"}, 128'(rd_req), 128'(0));
    chk({tag, "_wr_req"}, 128'(wr_req), 128'(0));
    chk({tag, "_busy"},   128'(busy),   128'(0));
    chk({tag, "_done"},   128'(done),   128'(0));
    chk({tag, "_found"},  128'(found),  128'(0));
    chk({tag, "_least"},  128'({least1, least2}), 128'(0));
    chk({tag, "_sum"},    128'(sum),    128'(0));
    chk({tag, "_addr"},   128'({rd_addr, wr_addr}), 128'(0));
  endtask

  // One scan: pulse start, wait (bounded) for done, then score result and write log
  task automatic do_scan(input int lim, input int max_cyc, input int poke_at,
                         input bit mid_chk, output int lat);
    res_t r;
    bit   seen_busy;
    seen_busy = 1'b0;
    clear_logs();
    limit = (IW+1)'(lim);
    start = 1'b1;
    lat   = 0;
    while (lat < max_cyc) begin
      tick();
      lat++;
      start = 1'b0;
      if (lat == poke_at) begin
        start = 1'b1;
        limit = '0;
      end
      if (mid_chk && lat == 10) begin
        chk("mid_found", 128'(found), 128'(0));
        chk("mid_sum", 128'(sum), 128'(0));
      end
      if (done) break;
      seen_busy |= busy;
    end
    start = 1'b0;
    chk("done_seen", 128'(done), 128'(1));
    if (done && exp_q.size() > 0) begin
      r = exp_q.pop_front();
      chk("busy_at_done", 128'(busy), 128'(0));
      chk("found", 128'(found), 128'(r.found));
      chk("least1", 128'(least1), 128'(r.l1));
      chk("least2", 128'(least2), 128'(r.l2));
      chk("sum", 128'(sum), 128'(r.sum));
      chk("wr_count", 128'(wr_log.size()), 128'(exp_wr.size()));
      for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
        chk("wr_order", 128'(wr_log[i]), 128'(exp_wr[i]));
    end
    exp_q.delete();
    exp_wr.delete();
    if (lim > 0) chk("busy_seen", 128'(seen_busy), 128'(1));
    tick();
    chk("done_pulse", 128'(done), 128'(0));
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; start = 1'b0; limit = '0;
    rd_valid = 1'b0; rd_data = '0; wr_ack = 1'b0;
    lat_min = 1; lat_max = 1; ack_dly = 0;
    rd_pend = 1'b0; rd_prev = 1'b0; wr_pend = 1'b0; rd_dn = 0; wr_wait = 0; rd_pa = '0; wr_pa = '0;
    clear_logs();
    tick();
    tick();
    chk_reset("rst");
    chk("rst_wr_data", 128'(wr_data), 128'(0));
    rst_n = 1'b1;
    tick();

    // Mixed table with a tie at count 3
    mem = '{64'd0, 64'd5, 64'd3, 64'd0, 64'd3, 64'd9, 64'd1, 64'd0};
    expect_res(2, 6, 2, 65'd4);
    exp_wr = '{6, 2};
    do_scan(8, 200, 0, 1'b0, lat);
    chk("t1_latency_ok", 128'(lat >= 26 && lat <= 28), 128'(1));
    chk("t1_rd_count", 128'(rd_n), 128'(8));
    chk("t1_mem2_wiped", 128'(mem[2]), 128'(0));
    chk("t1_mem4_kept", 128'(mem[4]), 128'(3));

    // Single live entry: no wipes
    mem = '{64'd0, 64'd0, 64'd0, 64'd0, 64'd7, 64'd0, 64'd0, 64'd0};
    expect_res(1, 4, 0, 65'd7);
    do_scan(8, 200, 0, 1'b0, lat);
    chk("t2_no_wr", 128'(wr_n), 128'(0));
    chk("t2_rd_count", 128'(rd_n), 128'(8));

    // Empty scan
    expect_res(0, 0, 0, 65'd0);
    do_scan(0, 20, 0, 1'b0, lat);
    chk("t3_latency_ok", 128'(lat >= 1 && lat <= 2), 128'(1));
    chk("t3_no_rd", 128'(rd_n), 128'(0));
    chk("t3_no_wr", 128'(wr_n), 128'(0));

    // Random read latency, slow write acks, all-equal counts
    lat_min = 1; lat_max = 5; ack_dly = 3;
    mem = '{64'd2, 64'd2, 64'd2, 64'd2, 64'd0, 64'd0, 64'd0, 64'd0};
    expect_res(2, 0, 1, 65'd4);
    exp_wr = '{0, 1};
    do_scan(4, 400, 0, 1'b0, lat);
    chk("t4_rd_count", 128'(rd_n), 128'(4));
    for (int i = 0; i < 4; i++) chk("t4_rd_hit", 128'(rd_hits[i]), 128'(1));

    // Maximum counts carry into the top sum bit
    lat_min = 1; lat_max = 1; ack_dly = 0;
    mem = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
    expect_res(2, 0, 1, 65'h1_FFFF_FFFF_FFFF_FFFE);
    exp_wr = '{0, 1};
    do_scan(8, 200, 0, 1'b0, lat);
    chk("t5_sum_carry", 128'(sum[CW]), 128'(1));

    // Reset during a read wait, reset during the first wipe, then a clean rescan
    lat_min = 3; lat_max = 3; ack_dly = 3;
    mem = '{64'd4, 64'd0, 64'd6, 64'd1, 64'd0, 64'd2, 64'd0, 64'd0};
    clear_logs();
    limit = 4'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_req_issued", 128'(rd_req), 128'(1));
    tick();
    rst_n = 1'b0;
    #1;
    chk_reset("t6_wait_rst");
    tick();
    rst_n = 1'b1;
    tick();

    clear_logs();
    limit = 4'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 200 && !wr_req; k++) tick();
    chk("t6_wipe_reached", 128'(wr_req), 128'(1));
    rst_n = 1'b0;
    #1;
    chk_reset("t6_wipe_rst");
    chk("t6_no_write_landed", 128'(mem[3]), 128'(1));
    tick();
    rst_n = 1'b1;
    tick();

    expect_res(2, 3, 5, 65'd3);
    exp_wr = '{3, 5};
    do_scan(8, 400, 7, 1'b1, lat);
    chk("t6_rd_count", 128'(rd_n), 128'(8));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/t05_least_pair_scanner.md
Name: t05_least_pair_scanner

Overview:
Parametrised successor to the single-mode least-value finder in the Huffman compression path. On each start, it scans a frequency/node table in SRAM over a request/valid read handshake and selects the two smallest non-zero entries. It then zero-wipes both entries over a write handshake and reports their indices and sum to the tree builder. It also reports when only one or zero live entries remain, which is the tree-build termination condition.

Parameters:
NUM_ENTRIES, 512, table depth (256 leaf histograms + internal nodes)
CNT_W, 64, width of each count word
IDX_W, $clog2(NUM_ENTRIES), index/address width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a scan (ignored unless idle)
limit  in  IDX_W+1  number of entries to scan (0..NUM_ENTRIES); captured at start
rd_req  out  1  one-cycle read request pulse
rd_addr  out  IDX_W  read address, valid while rd_req=1
rd_valid  in  1  read data valid; arbitrary latency of 1 or more cycles
rd_data  in  CNT_W  count at rd_addr
wr_req  out  1  write request; held until acked
wr_addr  out  IDX_W  wipe address
wr_data  out  CNT_W  always 0
wr_ack  in  1  write accepted; sampled while wr_req=1
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle completion pulse
found  out  2  live entries found: 0, 1 or 2 (2 means 2 or more)
least1  out  IDX_W  index of smallest count
least2  out  IDX_W  index of second smallest count
sum  out  CNT_W+1  count(least1)+count(least2), no truncation

Behaviour:
- Reset (async, rst_n=0): state IDLE. rd_req, wr_req, busy, done = 0. found, least1, least2, sum, rd_addr, wr_addr, wr_data = 0.
- States: IDLE, REQ, WAIT, CMP, WIPE1, WIPE2, FIN.
- IDLE: when start=1, capture limit, clamped to NUM_ENTRIES.
  - If the clamped limit is 0, go to FIN.
  - Otherwise go to REQ, with the scan pointer and both candidate slots cleared (invalid).
- REQ: rd_req=1 for exactly one cycle with rd_addr=pointer, then go to WAIT. At most one read is outstanding.
- WAIT: hold until rd_valid=1. Latch rd_data and go to CMP. rd_valid seen outside WAIT is ignored.
- CMP, for value v at index i:
  - v==0: skip.
  - slot1 invalid or v<m1: slot2<=slot1, slot1<=(i,v).
  - Else if slot2 invalid or v<m2: slot2<=(i,v).
  - Comparisons are strict, so on equal counts the lower index wins.
  - If pointer==limit-1, go to WIPE1 when both slots are valid, else go to FIN. Otherwise increment the pointer and go to REQ.
- Throughput: 3 cycles per entry at 1-cycle read latency.
- WIPE1: wr_req=1, wr_addr=least1, wr_data=0. On wr_ack go to WIPE2.
- WIPE2: same with wr_addr=least2. On wr_ack go to FIN.
- Each write completes in the cycle wr_ack is sampled high. wr_req drops for at least one cycle between the two writes.
- FIN: done=1 for one cycle, busy drops in the same cycle, return to IDLE.
- Outputs at done:
  - found = number of valid slots.
  - least1/least2 = slot indices; an invalid slot reads as 0.
  - sum = m1+m2; an invalid slot contributes 0.
  - These hold until the next accepted start.
- least1/least2/sum/found are updated only at FIN, never mid-scan.
- No wipes are issued when found<2.
- start while busy is ignored; no restart, no queueing.
- rst_n low mid-scan or mid-wipe aborts immediately, with all outputs at reset values. A wipe left half-done is tolerated by the controller.
- Counts at the maximum value (2^CNT_W−1) are legal. sum carries into bit CNT_W.

Test Plan:
- NUM_ENTRIES=8, table {0,5,3,0,3,9,1,0}, limit=8, 1-cycle latency -> least1=6, least2=2 (tie 3 vs 3: lower index), sum=4, found=2; wr to addr 6 then 2 with data 0; done pulses once. Total cycles from start to done = 24 read cycles + 2 write cycles (ack held high) + FIN, within ±1.
- Table all zero except index 4 = 7 -> found=1, least1=4, least2=0, sum=7, no wr_req ever asserted.
- limit=0 -> done two cycles after start, found=0, no rd_req.
- rd_valid latency randomised 1..5 and wr_ack delayed 3 cycles, table {2,2,2,2} -> least1=0, least2=1, sum=4; wr_req stable through each wait; exactly one rd_req per entry.
- Counts {2^64−1, 2^64−1, 0, ...}, CNT_W=64 -> sum=2^65−2, bit 64 set.
- rst_n pulsed low during WAIT and again during WIPE1; start pulsed while busy -> immediate reset values, a fresh start rescans correctly, and the mid-scan start does not alter the result.
